// File: rtl/cache_refill_controller.sv
// Refill sequencer for a direct-mapped 1024 x 128-bit cache serving one CPU requester.
// Latency: hit -> cpu_ready 2 cycles after acceptance; miss -> 3 + W cycles (W = MEM_WAIT cycles).
// Backpressure: one request in flight; cpu_read only sampled in IDLE, requester holds it until cpu_ready.
// Ports:
//   clock, reset                      : system clock, synchronous active-high reset
//   cpu_read/cpu_address              : CPU request in
//   cpu_ready/cpu_data/cpu_error      : CPU response (one-cycle ready pulse, data held)
//   cache_address/cache_hit/cache_out : cache lookup
//   cache_fill/cache_fill_data        : cache line write
//   mem_read/mem_address/mem_ready/mem_data : memory block fetch
//   hit_count/miss_count              : saturating statistics
module cache_refill_controller #(
  parameter int ADDR_W      = 15,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_address,
  output logic              cpu_ready,
  output logic [31:0]       cpu_data,
  output logic              cpu_error,
  output logic [ADDR_W-1:0] cache_address,
  input  logic              cache_hit,
  input  logic [31:0]       cache_out,
  output logic              cache_fill,
  output logic [127:0]      cache_fill_data,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_ready,
  input  logic [127:0]      mem_data,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_MEM_WAIT,
    S_REFILL,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  addr_q;
  logic [127:0]       fill_buf;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               tmo_last;
  logic [6:0]         word_lsb;

  assign tmo_last = (tmo_cnt == TMO_LAST);
  // Bit offset of the requested word inside a 128-bit block.
  assign word_lsb = {addr_q[1:0], 5'd0};

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; returned data takes priority over an expiring timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (cpu_read) state_nxt = S_COMPARE;
      S_COMPARE:  state_nxt = cache_hit ? S_DONE : S_MEM_WAIT;
      S_MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = S_REFILL;
        end else if (tmo_last) begin
          state_nxt = S_DONE;
        end
      end
      S_REFILL:   state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Control outputs decoded from the registered state only, so they cannot glitch.
  always_comb begin
    cpu_ready  = 1'b0;
    mem_read   = 1'b0;
    cache_fill = 1'b0;
    case (state)
      S_MEM_WAIT: mem_read   = 1'b1;
      S_REFILL:   cache_fill = 1'b1;
      S_DONE:     cpu_ready  = 1'b1;
      default:    ;
    endcase
  end

  assign cache_address   = addr_q;
  assign mem_address     = {addr_q[ADDR_W-1:2], 2'b00};
  assign cache_fill_data = fill_buf;

  // Datapath: request address, fill buffer, response registers, counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      fill_buf   <= '0;
      tmo_cnt    <= '0;
      cpu_data   <= '0;
      cpu_error  <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_read) addr_q <= cpu_address;
        end
        S_COMPARE: begin
          if (cache_hit) begin
            cpu_data  <= cache_out;
            cpu_error <= 1'b0;
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
          end else begin
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            tmo_cnt <= '0;
          end
        end
        S_MEM_WAIT: begin
          if (mem_ready) begin
            fill_buf  <= mem_data;
            cpu_data  <= mem_data[word_lsb +: 32];
            cpu_error <= 1'b0;
          end else if (tmo_last) begin
            cpu_data  <= '0;
            cpu_error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_controller.sv
// Bench for cache_refill_controller: behavioural cache and memory around the DUT,
// table of directed transactions, hand-written reset/idle corner sequences,
// then randomized transactions checked against a transaction-level model.
module tb_cache_refill_controller;

  localparam int ADDR_W = 15;
  localparam int TMO    = 64;
  localparam int CNT_W  = 5;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clock;
  logic              reset;
  logic              cpu_read;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_ready;
  logic [31:0]       cpu_data;
  logic              cpu_error;
  logic [ADDR_W-1:0] cache_address;
  logic              cache_hit;
  logic [31:0]       cache_out;
  logic              cache_fill;
  logic [127:0]      cache_fill_data;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_ready;
  logic [127:0]      mem_data;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  cache_refill_controller #(.ADDR_W(ADDR_W), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .cpu_read(cpu_read), .cpu_address(cpu_address),
    .cpu_ready(cpu_ready), .cpu_data(cpu_data), .cpu_error(cpu_error),
    .cache_address(cache_address), .cache_hit(cache_hit), .cache_out(cache_out),
    .cache_fill(cache_fill), .cache_fill_data(cache_fill_data),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_ready(mem_ready), .mem_data(mem_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural cache: 1024 lines of {valid, tag, 128-bit block}.
  logic [127:0] c_data  [1024];
  logic [2:0]   c_tag   [1024];
  logic         c_valid [1024];
  logic [9:0]   cidx;
  logic         cache_flush;
  int           fill_count = 0;

  assign cidx = cache_address[11:2];

  always_comb begin
    cache_hit = c_valid[cidx] && (c_tag[cidx] == cache_address[14:12]);
    cache_out = c_data[cidx][{cache_address[1:0], 5'd0} +: 32];
  end

  always @(posedge clock) begin
    if (cache_flush) begin
      for (int i = 0; i < 1024; i++) c_valid[i] <= 1'b0;
    end else if (cache_fill) begin
      c_valid[cidx] <= 1'b1;
      c_tag[cidx]   <= cache_address[14:12];
      c_data[cidx]  <= cache_fill_data;
      fill_count    <= fill_count + 1;
    end
  end

  // Memory contents as a pure function of the block address.
  function automatic logic [127:0] mem_block(input logic [12:0] blk);
    logic [127:0] b;
    logic [1:0]   kk;
    if (blk == 13'h0401) return 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    for (int k = 0; k < 4; k++) begin
      kk = 2'(k);
      b[32*k +: 32] = {3'b000, blk, kk, 14'h2A5A};
    end
    return b;
  endfunction

  function automatic logic [31:0] mem_word(input logic [14:0] a);
    logic [127:0] b;
    b = mem_block(a[14:2]);
    return b[{a[1:0], 5'd0} +: 32];
  endfunction

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One CPU read: cycle 0 is the IDLE cycle where cpu_read is sampled; memory answers in
  // the delay-th MEM_WAIT cycle (0 = never). noise scrambles cpu_read/cpu_address while waiting.
  task automatic run_read(input logic [14:0] addr, input int delay, input bit noise,
                          output int lat, output logic [31:0] data, output logic err,
                          output bit fill_seen, output logic [127:0] fill_dat,
                          output bit memrd_seen, output logic [14:0] memaddr);
    int waitc;
    waitc = 0; lat = -1; data = '0; err = 1'b0;
    fill_seen = 0; fill_dat = '0; memrd_seen = 0; memaddr = '0;
    @(negedge clock);
    cpu_read = 1'b1; cpu_address = addr; mem_ready = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      mem_ready = 1'b0;
      mem_data  = {$urandom, $urandom, $urandom, $urandom};
      if (mem_read) begin
        if (!memrd_seen) memaddr = mem_address;
        memrd_seen = 1;
        waitc++;
        if (waitc == delay) begin
          mem_ready = 1'b1;
          mem_data  = mem_block(addr[14:2]);
        end
        if (noise) begin
          cpu_read    = 1'($urandom_range(0, 1));
          cpu_address = 15'($urandom);
        end
      end
      if (cache_fill) begin
        fill_seen = 1;
        fill_dat  = cache_fill_data;
      end
      if (cpu_ready) begin
        lat  = c;
        data = cpu_data;
        err  = cpu_error;
        break;
      end
    end
    cpu_read  = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic do_txn(input string tag, input logic [14:0] addr, input int delay, input bit noise,
                        input bit exp_hit, input logic [31:0] exp_data, input bit exp_err,
                        input int exp_lat, input int exp_hc, input int exp_mc);
    int lat; logic [31:0] data; logic err; bit fs; logic [127:0] fd; bit mr; logic [14:0] ma;
    bit exp_fill;
    exp_fill = !exp_hit && !exp_err;
    run_read(addr, delay, noise, lat, data, err, fs, fd, mr, ma);
    check({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " cpu_data"}, 128'(data), 128'(exp_data));
    check({tag, " cpu_error"}, 128'(err), 128'(exp_err));
    check({tag, " fill_seen"}, 128'(fs), 128'(exp_fill));
    if (exp_fill) check({tag, " fill_data"}, fd, mem_block(addr[14:2]));
    check({tag, " mem_read_seen"}, 128'(mr), 128'(!exp_hit));
    if (!exp_hit) check({tag, " mem_address"}, 128'(ma), 128'({addr[14:2], 2'b00}));
    check({tag, " hit_count"}, 128'(hit_count), 128'(exp_hc));
    check({tag, " miss_count"}, 128'(miss_count), 128'(exp_mc));
  endtask

  typedef struct {
    logic [14:0] addr;
    int          delay;
    bit          noise;
    bit          hit;
    logic [31:0] data;
    bit          err;
    int          lat;
    int          hc;
    int          mc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit           got;
    int           waitc;
    int           fills0;
    bit           bad;
    bit           rv [1024];
    logic [2:0]   rt [1024];
    int           eh, em;
    logic [14:0]  a;
    int           d, r;
    bit           hit, tmo;

    // addr, delay(0=never), noise, hit, data, err, latency, hit_count, miss_count
    tbl[0] = '{15'h1005, 5,  0, 0, 32'hBBBBBBBB,       0, 8,  0, 1};
    tbl[1] = '{15'h1006, 5,  0, 1, 32'hCCCCCCCC,       0, 2,  1, 1};
    tbl[2] = '{15'h5004, 3,  1, 0, mem_word(15'h5004), 0, 6,  1, 2};
    tbl[3] = '{15'h1004, 2,  0, 0, 32'hAAAAAAAA,       0, 5,  1, 3};
    tbl[4] = '{15'h2001, 0,  0, 0, 32'h0,              1, 66, 1, 4};
    tbl[5] = '{15'h2001, 1,  1, 0, mem_word(15'h2001), 0, 4,  1, 5};
    tbl[6] = '{15'h2003, 1,  0, 1, mem_word(15'h2003), 0, 2,  2, 5};
    tbl[7] = '{15'h3002, 64, 0, 0, mem_word(15'h3002), 0, 67, 2, 6};

    reset = 1'b1; cache_flush = 1'b1;
    cpu_read = 1'b0; cpu_address = '0; mem_ready = 1'b0; mem_data = '0;
    repeat (3) @(negedge clock);
    check("rst cpu_ready", 128'(cpu_ready), 0);
    check("rst cpu_data", 128'(cpu_data), 0);
    check("rst cpu_error", 128'(cpu_error), 0);
    check("rst mem_read", 128'(mem_read), 0);
    check("rst cache_fill", 128'(cache_fill), 0);
    check("rst fill_data", cache_fill_data, 0);
    check("rst cache_address", 128'(cache_address), 0);
    check("rst mem_address", 128'(mem_address), 0);
    check("rst hit_count", 128'(hit_count), 0);
    check("rst miss_count", 128'(miss_count), 0);
    reset = 1'b0; cache_flush = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_txn($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].delay, tbl[i].noise, tbl[i].hit,
             tbl[i].data, tbl[i].err, tbl[i].lat, tbl[i].hc, tbl[i].mc);
    end

    // Stray mem_ready while idle must change nothing.
    @(negedge clock);
    mem_ready = 1'b1; mem_data = {4{32'h5A5A5A5A}};
    @(negedge clock);
    mem_ready = 1'b0;
    check("idle_pulse mem_read", 128'(mem_read), 0);
    check("idle_pulse cpu_ready", 128'(cpu_ready), 0);
    check("idle_pulse cache_fill", 128'(cache_fill), 0);
    check("idle_pulse cpu_data", 128'(cpu_data), 128'(mem_word(15'h3002)));
    check("idle_pulse hit_count", 128'(hit_count), 2);
    check("idle_pulse miss_count", 128'(miss_count), 6);

    // Reset in the 2nd MEM_WAIT cycle, then a late mem_ready.
    @(negedge clock);
    cpu_read = 1'b1; cpu_address = 15'h6008;
    got = 0; waitc = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clock);
      if (mem_read) begin
        waitc++;
        if (waitc == 2) begin
          reset = 1'b1; cpu_read = 1'b0; got = 1;
        end
      end
    end
    check("midwait reached", 128'(got), 1);
    @(negedge clock);
    check("midwait mem_read", 128'(mem_read), 0);
    check("midwait cache_fill", 128'(cache_fill), 0);
    check("midwait hit_count", 128'(hit_count), 0);
    check("midwait miss_count", 128'(miss_count), 0);
    reset = 1'b0;
    fills0 = fill_count;
    mem_ready = 1'b1; mem_data = mem_block(13'h1802);
    @(negedge clock);
    mem_ready = 1'b0;
    bad = 0;
    repeat (4) begin
      if (cpu_ready || cache_fill || mem_read) bad = 1;
      @(negedge clock);
    end
    check("late_ready quiet", 128'(bad), 0);
    check("late_ready fills", 128'(fill_count), 128'(fills0));
    do_txn("after_reset", 15'h6008, 2, 0, 0, mem_word(15'h6008), 0, 5, 0, 1);

    // Randomized phase against a transaction-level model.
    @(negedge clock);
    reset = 1'b1; cache_flush = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0; cache_flush = 1'b0;
    for (int i = 0; i < 1024; i++) begin rv[i] = 0; rt[i] = '0; end
    eh = 0; em = 0;
    for (int t = 0; t < 150; t++) begin
      a = {3'($urandom_range(0, 7)), 10'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      r = $urandom_range(0, 15);
      d = (r == 0) ? 0 : (r == 1) ? $urandom_range(60, 70) : $urandom_range(1, 6);
      hit = rv[a[11:2]] && (rt[a[11:2]] == a[14:12]);
      tmo = !hit && (d == 0 || d > TMO);
      if (hit) eh = (eh == CMAX) ? eh : eh + 1;
      else     em = (em == CMAX) ? em : em + 1;
      if (!hit && !tmo) begin rv[a[11:2]] = 1; rt[a[11:2]] = a[14:12]; end
      do_txn($sformatf("rnd%0d", t), a, d, 1'($urandom_range(0, 1)), hit,
             tmo ? 32'h0 : mem_word(a), tmo,
             hit ? 2 : (tmo ? 2 + TMO : 3 + d), eh, em);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
